// File: rtl/store_pkg.sv
// Shared types for the store formatting path: funct3 codes,
// FIFO entry layout and the idle write-enable pattern.
package store_pkg;

  localparam int STORE_ADDR_W = 16;
  localparam int WADDR_W      = STORE_ADDR_W - 2;

  localparam logic [3:0] WEB_IDLE = 4'hF;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010
  } store_op_e;

  typedef struct packed {
    logic [3:0]         web;
    logic [WADDR_W-1:0] waddr;
    logic [31:0]        data;
  } store_entry_t;

endpackage

// File: rtl/store_formatter_if.sv
// Store request and data-memory write port bundle.
// master = request producer / memory model, slave = formatter.
interface store_formatter_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;

  logic              mem_cs;
  logic [3:0]        mem_web;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_di;
  logic              mem_stall;

  modport master (
    output req_valid, req_funct3, req_addr, req_data,
    input  req_ready,
    input  mem_cs, mem_web, mem_addr, mem_di,
    output mem_stall
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_data,
    output req_ready,
    output mem_cs, mem_web, mem_addr, mem_di,
    input  mem_stall
  );

endinterface

// File: rtl/store_fifo.sv
// In-order FIFO of formatted store entries.
// DEPTH must be a power of two; pointers wrap naturally.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  store_entry_t din,
  input  logic         pop,
  output store_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count
);

  store_entry_t mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/store_formatter.sv
// Store lane formatter: SB/SH/SW to byte lanes + active-low WEB.
// STORE_MISALIGN_TRAP_EN: reject misaligned SH/SW instead of aligning down.
module store_formatter
  import store_pkg::*;
#(
  parameter int ADDR_W = STORE_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  store_formatter_if.slave  bus,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int PW = $clog2(DEPTH);

  store_entry_t ent;
  store_entry_t head;
  logic         is_sb, is_sh, is_sw;
  logic         misal, bad, accept, push, pop;
  logic         full, empty;
  logic [PW:0]  count;

  assign is_sb = (bus.req_funct3 == STORE_SB);
  assign is_sh = (bus.req_funct3 == STORE_SH);
  assign is_sw = (bus.req_funct3 == STORE_SW);
  assign misal = (is_sh && bus.req_addr[0]) ||
                 (is_sw && (bus.req_addr[1:0] != 2'b00));

`ifdef STORE_MISALIGN_TRAP_EN
  assign bad = !(is_sb || is_sh || is_sw) || misal;
`else
  logic unused_misal;
  assign unused_misal = misal;
  assign bad = !(is_sb || is_sh || is_sw);
`endif

  always_comb begin
    ent       = '0;
    ent.web   = WEB_IDLE;
    ent.waddr = bus.req_addr[ADDR_W-1:2];
    unique case (1'b1)
      is_sb: begin
        ent.data = {4{bus.req_data[7:0]}};
        ent.web  = ~(4'b0001 << bus.req_addr[1:0]);
      end
      is_sh: begin
        ent.data = {2{bus.req_data[15:0]}};
        ent.web  = bus.req_addr[1] ? 4'b0011 : 4'b1100;
      end
      is_sw: begin
        ent.data = bus.req_data;
        ent.web  = 4'b0000;
      end
      default: ;
    endcase
  end

  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign push          = accept && !bad;
  assign pop           = !empty && !bus.mem_stall;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Stale storage never reaches the port while the FIFO is empty.
  assign bus.mem_cs   = !empty;
  assign bus.mem_web  = empty ? WEB_IDLE : head.web;
  assign bus.mem_addr = empty ? '0 : head.waddr;
  assign bus.mem_di   = empty ? '0 : head.data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= accept && bad;
      if (accept && bad && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_store_formatter.sv
// Directed self-checking bench for store_formatter.
module tb_store_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic       err;
  logic [7:0] err_cnt;
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;

  store_formatter_if #(.ADDR_W(16)) bus ();

  store_formatter #(.ADDR_W(16), .DEPTH(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [2:0] f3,
                     input logic [15:0] a, input logic [31:0] d);
    bus.req_valid  = v;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_data   = d;
  endtask

  initial begin
    rst           = 1'b0;
    bus.mem_stall = 1'b0;
    req(1'b0, 3'd0, 16'h0, 32'h0);
    #12;
    chk("rst_cs", 32'(bus.mem_cs), 32'd0);
    chk("rst_web", 32'(bus.mem_web), 32'hF);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_di", bus.mem_di, 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // SB, lane 3
    req(1'b1, 3'b000, 16'h1003, 32'h12345678);
    chk("sb_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("sb_cs", 32'(bus.mem_cs), 32'd1);
    chk("sb_addr", 32'(bus.mem_addr), 32'h400);
    chk("sb_di", bus.mem_di, 32'h78787878);
    chk("sb_web", 32'(bus.mem_web), 32'b0111);
    chk("sb_err", 32'(err), 32'd0);
    step();
    chk("sb_done_cs", 32'(bus.mem_cs), 32'd0);

    // SB, lane 1
    req(1'b1, 3'b000, 16'h0001, 32'hFFFF00AB);
    step();
    bus.req_valid = 1'b0;
    chk("sb1_di", bus.mem_di, 32'hABABABAB);
    chk("sb1_web", 32'(bus.mem_web), 32'b1101);
    step();

    // SH, upper half
    req(1'b1, 3'b001, 16'h0002, 32'h0000BEEF);
    step();
    bus.req_valid = 1'b0;
    chk("sh_cs", 32'(bus.mem_cs), 32'd1);
    chk("sh_di", bus.mem_di, 32'hBEEFBEEF);
    chk("sh_web", 32'(bus.mem_web), 32'b0011);
    chk("sh_addr", 32'(bus.mem_addr), 32'h0);
    step();

    // Back-pressure: five stalled edges, three SW offered
    bus.mem_stall = 1'b1;
    req(1'b1, 3'b010, 16'h0010, 32'h11111111);
    step();
    req(1'b1, 3'b010, 16'h0014, 32'h22222222);
    chk("bp_ready1", 32'(bus.req_ready), 32'd1);
    step();
    req(1'b1, 3'b010, 16'h0018, 32'h33333333);
    chk("bp_full", 32'(bus.req_ready), 32'd0);
    chk("bp_hold_addr", 32'(bus.mem_addr), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_stall_addr", 32'(bus.mem_addr), 32'h4);
      chk("bp_stall_di", bus.mem_di, 32'h11111111);
    end
    bus.mem_stall = 1'b0;
    step();
    chk("bp_w1_addr", 32'(bus.mem_addr), 32'h5);
    chk("bp_w1_di", bus.mem_di, 32'h22222222);
    chk("bp_ready2", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    chk("bp_w2_cs", 32'(bus.mem_cs), 32'd1);
    chk("bp_w2_addr", 32'(bus.mem_addr), 32'h6);
    chk("bp_w2_di", bus.mem_di, 32'h33333333);
    step();
    chk("bp_drain_cs", 32'(bus.mem_cs), 32'd0);

    // Misaligned SW
    req(1'b1, 3'b010, 16'h0006, 32'hCAFEF00D);
    step();
    bus.req_valid = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    exp_cnt++;
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_errcnt", 32'(err_cnt), 32'(exp_cnt));
    chk("mis_cs", 32'(bus.mem_cs), 32'd0);
`else
    chk("mis_err", 32'(err), 32'd0);
    chk("mis_cs", 32'(bus.mem_cs), 32'd1);
    chk("mis_addr", 32'(bus.mem_addr), 32'h1);
    chk("mis_web", 32'(bus.mem_web), 32'b0000);
    chk("mis_di", bus.mem_di, 32'hCAFEF00D);
`endif
    step();
    chk("mis_err_end", 32'(err), 32'd0);
    chk("mis_cs_end", 32'(bus.mem_cs), 32'd0);

    // Illegal funct3
    req(1'b1, 3'b111, 16'h0020, 32'h0);
    step();
    bus.req_valid = 1'b0;
    exp_cnt++;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_errcnt", 32'(err_cnt), 32'(exp_cnt));
    chk("ill_cs", 32'(bus.mem_cs), 32'd0);
    step();
    chk("ill_err_end", 32'(err), 32'd0);

    // Reset with two stalled entries pending
    bus.mem_stall = 1'b1;
    req(1'b1, 3'b010, 16'h0040, 32'h00000001);
    step();
    req(1'b1, 3'b010, 16'h0044, 32'h00000002);
    step();
    bus.req_valid = 1'b0;
    chk("mr_cs", 32'(bus.mem_cs), 32'd1);
    chk("mr_full", 32'(bus.req_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_async_cs", 32'(bus.mem_cs), 32'd0);
    chk("mr_async_web", 32'(bus.mem_web), 32'hF);
    chk("mr_async_addr", 32'(bus.mem_addr), 32'h0);
    chk("mr_async_di", bus.mem_di, 32'h0);
    chk("mr_async_ready", 32'(bus.req_ready), 32'd1);
    chk("mr_async_errcnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_stall = 1'b0;
    step();
    chk("mr_post_cs1", 32'(bus.mem_cs), 32'd0);
    step();
    chk("mr_post_cs2", 32'(bus.mem_cs), 32'd0);
    chk("mr_post_ready", 32'(bus.req_ready), 32'd1);

    // err_cnt saturation
    req(1'b1, 3'b111, 16'h0, 32'h0);
    for (int i = 0; i < 300; i++) step();
    bus.req_valid = 1'b0;
    chk("sat_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_err", 32'(err), 32'd1);
    chk("sat_cs", 32'(bus.mem_cs), 32'd0);
    step();
    chk("sat_cnt_hold", 32'(err_cnt), 32'hFF);
    chk("sat_err_end", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_formatter.md
# store_formatter

Store-side counterpart of the load extension path: accepts 32-bit store requests (SB/SH/SW), narrows and replicates the data onto the correct byte lanes, and generates active-low per-byte write enables for the 32-bit data SRAM. Sits between the execute stage and the data-memory port. A small in-order FIFO with a valid/ready handshake absorbs memory back-pressure.

## Interface
- `ADDR_W`, 16: byte-address width; the memory word address is `ADDR_W-2` bits.
- `DEPTH`, 2: FIFO entries; must be a power of 2, ≥ 2.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: store request present.
- `req_ready` out 1: FIFO can accept this cycle.
- `req_funct3` in 3: 000 = SB, 001 = SH, 010 = SW; other codes are illegal.
- `req_addr` in `ADDR_W`: byte address.
- `req_data` in 32: rs2 value; only the low 8/16/32 bits are used.
- `mem_cs` out 1: write valid to memory.
- `mem_web` out 4: active-low byte write enables; bit i covers bits [8i+7:8i].
- `mem_addr` out `ADDR_W-2`: word address.
- `mem_di` out 32: formatted write data.
- `mem_stall` in 1: memory cannot take a write this cycle.
- `err` out 1: one-cycle pulse for a rejected request.
- `err_cnt` out 8: saturating count of rejected requests.

## Operation
- **Handshake:** a request is accepted on a rising edge when `req_valid && req_ready`. `req_ready = (count < DEPTH)`. It does not look ahead for a same-cycle pop.
- **Formatting:** combinational on the request; the formatted entry `{web, waddr, data}` is pushed into the FIFO.
  - SB: data = `{4{req_data[7:0]}}`. The `web` lane selected by `addr[1:0]` is 0; the others are 1.
  - SH: data = `{2{req_data[15:0]}}`. `addr[1]=0` gives web 4'b1100; `addr[1]=1` gives 4'b0011.
  - SW: data = `req_data`, web = 4'b0000.
  - `waddr = req_addr[ADDR_W-1:2]`.
- **Illegal funct3:** the request is accepted but not pushed. `err` pulses and `err_cnt` increments.
- **Misalignment:** SH with `addr[0]=1`, or SW with `addr[1:0]≠0`. Handling depends on `STORE_MISALIGN_TRAP_EN` (see Configuration).
- **Memory side:** `mem_*` present the FIFO head directly from registered storage.
  - `mem_cs = !empty`.
  - A write completes, and the head pops, on an edge where `mem_cs && !mem_stall`.
  - When the FIFO is empty: `mem_web = 4'hF`, `mem_di = 0`, `mem_addr = 0`.
- **Pointers and count:**
  - Read and write pointers wrap modulo `DEPTH`.
  - Simultaneous push and pop leave `count` unchanged.
  - Entries leave strictly in acceptance order.
- **`err_cnt`:** saturates at 8'hFF.

## Timing
- **Reset (`rst` low, asynchronous):**
  - `count = 0` and both pointers = 0.
  - `mem_cs = 0`, `mem_web = 4'hF`, `mem_addr = 0`, `mem_di = 0`.
  - `req_ready = 1`, `err = 0`, `err_cnt = 0`.
  - Pending entries are discarded and no partial write is issued.
  - Release is taken synchronously on the next edge.
- **Latency:** a request accepted at edge N drives `mem_cs = 1` with its data in cycle N+1. It completes at the first later edge with `mem_stall = 0`.
- **Throughput:** one store per cycle with `mem_stall` low and `DEPTH ≥ 2`.
- **Full FIFO:** `req_ready` is low in the cycle after the `DEPTH`-th outstanding push. It rises in the cycle after the first pop.
- **`err`:** high for exactly the cycle after the rejecting edge.
- **`req_valid` low:** `req_*` are don't-care.
- **Stall:** `mem_*` hold stable while `mem_stall` is high.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined:
  - Misaligned requests are accepted but not pushed.
  - `err` pulses and `err_cnt` increments.
  - No memory write occurs.
- `STORE_MISALIGN_TRAP_EN` undefined:
  - Misalignment is ignored; `addr[0]` is dropped for SH and `addr[1:0]` for SW.
  - The write proceeds to the aligned-down lanes: SH uses lanes by `addr[1]`; SW writes the full word.
  - Only illegal funct3 raises `err`.

## Structure
- Shared package `store_pkg`:
  - funct3 enum `STORE_SB`/`STORE_SH`/`STORE_SW`.
  - Packed struct `store_entry_t {web[3:0], waddr, data[31:0]}`.
  - Constant `WEB_IDLE = 4'hF`.
- Sub-module `store_fifo`: parameterised synchronous FIFO of `store_entry_t` with push/pop/full/empty/count.
- Top level keeps the formatting logic, error detection and `err_cnt`.

## Test plan
- **SB:** SB addr 0x1003, data 0x12345678, `mem_stall = 0` → next cycle `mem_cs = 1`, `mem_addr = 0x400`, `mem_di = 0x78787878`, `mem_web = 4'b0111`.
- **SH:** SH addr 0x0002, data 0x0000BEEF → `mem_di = 0xBEEFBEEF`, `mem_web = 4'b0011`, `mem_addr = 0x000`.
- **Back-pressure:**
  - Stimulus: `mem_stall = 1` for 5 cycles; SW to 0x10, 0x14, 0x18 offered back-to-back.
  - Response: 2 accepted, then `req_ready = 0`. After the stall releases, writes go out in order 0x4, 0x5, 0x6 on consecutive cycles.
- **Misaligned SW and illegal funct3:**
  - SW addr 0x0006 with the macro defined → `err` pulse, `err_cnt = 1`, `mem_cs` stays 0.
  - Same request without the macro → write with `mem_addr = 0x1`, `mem_web = 4'b0000`.
  - funct3 = 3'b111 → `err` pulse in both builds.
- **Reset mid-operation:** FIFO holding 2 entries with `mem_stall = 1`; drive `rst` low mid-cycle → `mem_cs = 0` and `mem_web = 4'hF` immediately. After release, no stale write appears and `req_ready = 1`.
- **`err_cnt` saturation:** 300 illegal requests → `err_cnt = 8'hFF`, no wrap.
